// File: rtl/uart_tx_serial.sv
// uart_tx_serial: framed UART transmitter (start, LSB-first data,
// optional parity, 1-2 stop bits), bit period = RCONST clocks.
module uart_tx_serial #(
  parameter int RCONST    = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] sbyte,
  input  logic       send,
  output logic       tx,
  output logic       busy
);

  localparam int P     = (PARITY != 0) ? 1 : 0;
  localparam int NBITS = 1 + DATA_BITS + P + STOP_BITS;
  localparam int DW    = (RCONST > 2) ? $clog2(RCONST) : 1;

  localparam logic [DW-1:0] DIV_MAX   = DW'(RCONST - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS);
  localparam logic [3:0]    LAST_BIT  = 4'(NBITS - 1);
  localparam logic [7:0]    MASK      = 8'((1 << DATA_BITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state, w_state_n;
  logic [DW-1:0] r_div, w_div_n;
  logic [3:0]    r_cnt, w_cnt_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_par, w_par_n;
  logic          r_tx, w_tx_n;
  logic          r_busy, w_busy_n;

  logic [7:0] w_data;
  logic       w_bound;
  logic       w_frame_end;
  logic       w_accept;

  assign w_data      = sbyte & MASK;
  assign w_bound     = (r_div == DIV_MAX);
  assign w_frame_end = (r_state == S_STOP) && w_bound
                     && (r_cnt == LAST_BIT);
  // accepting on the last stop edge keeps streamed frames gap-free
  assign w_accept    = send && ((r_state == S_IDLE) || w_frame_end);

  always_ff @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_div   <= w_div_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;

    if (r_state != S_IDLE) begin
      if (w_bound) begin
        w_div_n = '0;
        w_cnt_n = r_cnt + 4'd1;
      end else begin
        w_div_n = r_div + DW'(1);
      end
    end

    unique case (r_state)
      S_IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
      end
      S_START: begin
        if (w_bound) begin
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
          w_shift_n = {1'b0, r_shift[7:1]};
        end
      end
      S_DATA: begin
        if (w_bound) begin
          if (r_cnt == LAST_DATA) begin
            if (P != 0) begin
              w_state_n = S_PARITY;
              w_tx_n    = r_par;
            end else begin
              w_state_n = S_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_tx_n    = r_shift[0];
            w_shift_n = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (w_bound) begin
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_frame_end) begin
          w_state_n = S_IDLE;
          w_tx_n    = 1'b1;
          w_busy_n  = 1'b0;
          w_cnt_n   = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    if (w_accept) begin
      w_state_n = S_START;
      w_div_n   = '0;
      w_cnt_n   = '0;
      w_shift_n = w_data;
      w_par_n   = (PARITY == 1) ? ~(^w_data) : (^w_data);
      w_tx_n    = 1'b0;
      w_busy_n  = 1'b1;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_serial.sv
// tb_uart_tx_serial: 8N1 and 8E2 transmitters checked against a
// frame-level reference model plus directed frame tables.
module tb_uart_tx_serial;

  localparam int RA = 108;
  localparam int RB = 16;

  logic       clk100 = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] sbyte  = 8'h00;
  logic       send_a = 1'b0;
  logic       send_b = 1'b0;
  logic       tx_a, busy_a;
  logic       tx_b, busy_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk100 = ~clk100;

  uart_tx_serial #(
    .RCONST(RA), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk100(clk100), .reset(reset), .sbyte(sbyte),
    .send(send_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_serial #(
    .RCONST(RB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk100(clk100), .reset(reset), .sbyte(sbyte),
    .send(send_b), .tx(tx_b), .busy(busy_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] frame_bits(
    logic [7:0] b, int db, int par, int sb);
    logic [11:0] f;
    int          k;
    bit          p;
    f = '0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[k] = b[i];
      p    = p ^ b[i];
      k++;
    end
    if (par != 0) begin
      f[k] = (par == 2) ? p : !p;
      k++;
    end
    for (int i = 0; i < sb; i++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  // frame-level models: clock index into the current frame
  bit          ba = 1'b0, bb = 1'b0;
  int          ta = 0, tb = 0;
  int          la = 10, lb = 12;
  logic [11:0] fa = '1, fb = '1;

  always @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      ba = 1'b0;
      ta = 0;
    end else begin
      if (ba) begin
        ta++;
        if (ta == la * RA) ba = 1'b0;
      end
      if (!ba && send_a) begin
        fa = frame_bits(sbyte, 8, 0, 1);
        la = 10;
        ta = 0;
        ba = 1'b1;
      end
    end
  end

  always @(posedge clk100 or negedge reset) begin
    if (!reset) begin
      bb = 1'b0;
      tb = 0;
    end else begin
      if (bb) begin
        tb++;
        if (tb == lb * RB) bb = 1'b0;
      end
      if (!bb && send_b) begin
        fb = frame_bits(sbyte, 8, 2, 2);
        lb = 12;
        tb = 0;
        bb = 1'b1;
      end
    end
  end

  always @(negedge clk100) begin
    chk("model_tx_a", tx_a, ba ? fa[ta / RA] : 1'b1);
    chk("model_busy_a", busy_a, ba);
    chk("model_tx_b", tx_b, bb ? fb[tb / RB] : 1'b1);
    chk("model_busy_b", busy_b, bb);
  end

  typedef struct {
    bit          use_b;
    logic [7:0]  b;
    logic [11:0] bits;
    int          n;
    int          inj;
  } vec_t;

  vec_t tbl[7];

  task automatic run_frame(input vec_t v);
    int   r;
    int   busy_cnt;
    logic txv, bv;
    r        = v.use_b ? RB : RA;
    busy_cnt = 0;
    @(negedge clk100);
    sbyte = v.b;
    if (v.use_b) send_b = 1'b1;
    else send_a = 1'b1;
    @(negedge clk100);
    send_a = 1'b0;
    send_b = 1'b0;
    for (int t = 0; t < v.n * r + 4; t++) begin
      if (t == v.inj) begin
        sbyte = 8'hFF;
        if (v.use_b) send_b = 1'b1;
        else send_a = 1'b1;
      end
      if (t == v.inj + 1) begin
        send_a = 1'b0;
        send_b = 1'b0;
      end
      txv = v.use_b ? tx_b : tx_a;
      bv  = v.use_b ? busy_b : busy_a;
      if ((t % r) == r / 2 && (t / r) < v.n)
        chk($sformatf("bit%0d_of_%h", t / r, v.b),
            txv, v.bits[t / r]);
      if (bv) busy_cnt++;
      @(negedge clk100);
    end
    chk($sformatf("busy_len_%h", v.b), busy_cnt, v.n * r);
    txv = v.use_b ? tx_b : tx_a;
    bv  = v.use_b ? busy_b : busy_a;
    chk($sformatf("idle_tx_%h", v.b), txv, 1'b1);
    chk($sformatf("idle_busy_%h", v.b), bv, 1'b0);
  endtask

  initial begin
    int lowcnt;
    logic [11:0] pat;

    tbl[0] = '{1'b0, 8'h41, 12'h282, 10, -1};
    tbl[1] = '{1'b0, 8'h41, 12'h282, 10, 300};
    tbl[2] = '{1'b0, 8'h00, 12'h200, 10, -1};
    tbl[3] = '{1'b0, 8'hFF, 12'h3FE, 10, -1};
    tbl[4] = '{1'b1, 8'h07, 12'hE0E, 12, -1};
    tbl[5] = '{1'b1, 8'h00, 12'hC00, 12, -1};
    tbl[6] = '{1'b1, 8'h80, 12'hF00, 12, -1};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      send_a = ~send_a;
      send_b = ~send_b;
      sbyte  = 8'($urandom);
    end
    send_a = 1'b0;
    send_b = 1'b0;
    @(negedge clk100);
    reset = 1'b1;
    repeat (50) @(negedge clk100);
    chk("rst_release_tx_a", tx_a, 1'b1);
    chk("rst_release_busy_a", busy_a, 1'b0);
    chk("rst_release_tx_b", tx_b, 1'b1);
    chk("rst_release_busy_b", busy_b, 1'b0);

    foreach (tbl[i]) run_frame(tbl[i]);

    // continuous 0x55 stream: three frames, no idle gap
    pat = 12'h2AA;
    @(negedge clk100);
    sbyte  = 8'h55;
    send_a = 1'b1;
    @(negedge clk100);
    lowcnt = 0;
    for (int t = 0; t < 30 * RA; t++) begin
      if (!busy_a) lowcnt++;
      if ((t % RA) == RA / 2)
        chk("b2b_bit", tx_a, pat[(t / RA) % 10]);
      if (t == 30 * RA - 20) send_a = 1'b0;
      @(negedge clk100);
    end
    chk("b2b_busy_gaps", lowcnt, 0);
    chk("b2b_end_busy", busy_a, 1'b0);

    @(negedge clk100);
    sbyte  = 8'h41;
    send_a = 1'b1;
    @(negedge clk100);
    send_a = 1'b0;
    repeat (4 * RA + 50) @(negedge clk100);
    chk("pre_rst_busy", busy_a, 1'b1);
    chk("pre_rst_tx", tx_a, 1'b0);
    @(posedge clk100);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", tx_a, 1'b1);
    chk("async_rst_busy", busy_a, 1'b0);
    repeat (5) @(negedge clk100);
    reset = 1'b1;
    repeat (300) @(negedge clk100);
    chk("post_rst_tx", tx_a, 1'b1);
    chk("post_rst_busy", busy_a, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk100);
      sbyte  = 8'($urandom);
      send_a = ($urandom_range(0, 49) == 0);
      send_b = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk100);
    send_a = 1'b0;
    send_b = 1'b0;
    repeat (10) @(negedge clk100);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
